// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-access stage: access width, unit state and the
// data-memory request record.
package mem_access_unit_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_access_width_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_unit_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
  } dmem_req_t;

  // Encoding 3 is folded into WORD.
  function automatic mem_access_width_e to_width(input logic [1:0] raw);
    case (raw)
      2'd0:    to_width = BYTE;
      2'd1:    to_width = HALF;
      default: to_width = WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_access_width_e width,
                                         input logic [1:0] lane);
    is_misaligned = ((width == HALF) && lane[0]) ||
                    ((width == WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus. Request: a transfer happens on a cycle
// where req_valid && req_ready; the master holds every req_* field stable
// while req_valid is high and ready is low. Response: resp_valid marks one
// cycle of resp_rdata and is never back-pressured.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication and byte enables, load shift and
// sign/zero extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  mem_access_width_e  width,
  input  logic [1:0]         lane,
  input  logic               is_unsigned,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  rdata,
  output logic [DATA_W-1:0]  store_wdata,
  output logic [3:0]         store_be,
  output logic [DATA_W-1:0]  load_data
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted     = rdata >> {lane, 3'b000};
    store_wdata = wdata;
    store_be    = 4'b1111;
    load_data   = rdata;
    case (width)
      BYTE: begin
        store_wdata = {4{wdata[7:0]}};
        store_be    = 4'b0001 << lane;
        load_data   = is_unsigned ? {24'b0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        store_wdata = {2{wdata[15:0]}};
        store_be    = 4'b0011 << lane;
        load_data   = is_unsigned ? {16'b0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        store_wdata = wdata;
        store_be    = 4'b1111;
        load_data   = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage engine: issues data-memory requests, waits for load
// data, and produces the registered write-back pipeline register.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_W-1:0]     in_pc,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [1:0]            in_width,
  input  logic                  in_is_load,
  input  logic                  in_is_store,
  input  logic                  in_is_load_unsigned,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_rd_wen,
  output logic                  stall,
  mem_access_unit_if.master     dmem,
  output logic                  wb_valid,
  output logic [ADDR_W-1:0]     wb_pc,
  output logic [DATA_W-1:0]     wb_r_data,
  output logic [DATA_W-1:0]     wb_alu_result,
  output logic                  wb_is_load,
  output logic [REG_ADDR_W-1:0] wb_rd_addr,
  output logic                  wb_rd_wen,
  output logic                  wb_misaligned,
  output mem_unit_state_e       dbg_state
);

  mem_unit_state_e       state;
  dmem_req_t             req_q;
  logic [ADDR_W-1:0]     op_pc;
  logic [DATA_W-1:0]     op_alu_result;
  mem_access_width_e     op_width;
  logic                  op_is_load;
  logic                  op_is_unsigned;
  logic [REG_ADDR_W-1:0] op_rd_addr;
  logic                  op_rd_wen;

  mem_access_width_e in_width_n;
  logic              in_is_mem;
  logic              in_misaligned;
  mem_access_width_e align_width;
  logic [1:0]        align_lane;
  logic [DATA_W-1:0] st_wdata;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] ld_data;

  assign in_width_n    = to_width(in_width);
  assign in_is_mem     = in_is_load || in_is_store;
  assign in_misaligned = is_misaligned(in_width_n, in_alu_result[1:0]);

  // The aligner serves the incoming op while idle and the latched op afterwards.
  assign align_width = (state == IDLE) ? in_width_n : op_width;
  assign align_lane  = (state == IDLE) ? in_alu_result[1:0] : op_alu_result[1:0];

  mem_lane_align u_align (
    .width       (align_width),
    .lane        (align_lane),
    .is_unsigned (op_is_unsigned),
    .wdata       (in_wdata),
    .rdata       (dmem.resp_rdata),
    .store_wdata (st_wdata),
    .store_be    (st_be),
    .load_data   (ld_data)
  );

  assign stall          = (state == REQ) || (state == WAIT);
  assign dbg_state      = state;
  assign dmem.req_valid = (state == REQ);
  assign dmem.req_we    = req_q.we;
  assign dmem.req_addr  = req_q.addr;
  assign dmem.req_wdata = req_q.wdata;
  assign dmem.req_be    = req_q.be;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_q          <= '0;
      op_pc          <= '0;
      op_alu_result  <= '0;
      op_width       <= BYTE;
      op_is_load     <= 1'b0;
      op_is_unsigned <= 1'b0;
      op_rd_addr     <= '0;
      op_rd_wen      <= 1'b0;
      wb_valid       <= 1'b0;
      wb_pc          <= '0;
      wb_r_data      <= '0;
      wb_alu_result  <= '0;
      wb_is_load     <= 1'b0;
      wb_rd_addr     <= '0;
      wb_rd_wen      <= 1'b0;
      wb_misaligned  <= 1'b0;
    end else begin
      wb_valid      <= 1'b0;
      wb_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_pc          <= in_pc;
            op_alu_result  <= in_alu_result;
            op_width       <= in_width_n;
            op_is_load     <= in_is_load;
            op_is_unsigned <= in_is_load_unsigned;
            op_rd_addr     <= in_rd_addr;
            op_rd_wen      <= in_rd_wen;
            if (!in_is_mem || in_misaligned) begin
              // Completes without touching the bus.
              wb_valid      <= 1'b1;
              wb_pc         <= in_pc;
              wb_alu_result <= in_alu_result;
              wb_r_data     <= '0;
              wb_is_load    <= in_is_mem && in_is_load;
              wb_rd_addr    <= in_rd_addr;
              wb_rd_wen     <= in_rd_wen && !in_is_mem;
              wb_misaligned <= in_is_mem;
            end else begin
              state       <= REQ;
              req_q.we    <= !in_is_load;
              req_q.addr  <= {in_alu_result[ADDR_W-1:2], 2'b00};
              req_q.wdata <= st_wdata;
              req_q.be    <= st_be;
            end
          end
        end
        REQ: begin
          if (dmem.req_ready) begin
            if (op_is_load) begin
              state <= WAIT;
            end else begin
              state         <= IDLE;
              wb_valid      <= 1'b1;
              wb_pc         <= op_pc;
              wb_alu_result <= op_alu_result;
              wb_r_data     <= '0;
              wb_is_load    <= 1'b0;
              wb_rd_addr    <= op_rd_addr;
              wb_rd_wen     <= op_rd_wen;
            end
          end
        end
        WAIT: begin
          if (dmem.resp_valid) begin
            state         <= IDLE;
            wb_valid      <= 1'b1;
            wb_pc         <= op_pc;
            wb_alu_result <= op_alu_result;
            wb_r_data     <= ld_data;
            wb_is_load    <= 1'b1;
            wb_rd_addr    <= op_rd_addr;
            wb_rd_wen     <= op_rd_wen;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of ops with hand-computed
// request/write-back values, plus reset-in-flight sequences.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc, in_alu_result, in_wdata;
  logic [1:0]  in_width;
  logic        in_is_load, in_is_store, in_is_load_unsigned;
  logic [4:0]  in_rd_addr;
  logic        in_rd_wen;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_pc, wb_r_data, wb_alu_result;
  logic        wb_is_load;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_wen, wb_misaligned;
  mem_unit_state_e dbg_state;

  mem_access_unit_if dmem ();

  mem_access_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_pc               (in_pc),
    .in_alu_result       (in_alu_result),
    .in_wdata            (in_wdata),
    .in_width            (in_width),
    .in_is_load          (in_is_load),
    .in_is_store         (in_is_store),
    .in_is_load_unsigned (in_is_load_unsigned),
    .in_rd_addr          (in_rd_addr),
    .in_rd_wen           (in_rd_wen),
    .stall               (stall),
    .dmem                (dmem.master),
    .wb_valid            (wb_valid),
    .wb_pc               (wb_pc),
    .wb_r_data           (wb_r_data),
    .wb_alu_result       (wb_alu_result),
    .wb_is_load          (wb_is_load),
    .wb_rd_addr          (wb_rd_addr),
    .wb_rd_wen           (wb_rd_wen),
    .wb_misaligned       (wb_misaligned),
    .dbg_state           (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before time limit");
    $fatal(1);
  end

  // Scoreboard
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_load, is_store, is_uns;
    logic [1:0]  width;
    logic [31:0] addr, wdata, rdata;
    int          rdy_dly, rsp_dly;
    logic        rd_wen;
    logic        exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    logic        exp_is_load, exp_mis, exp_rd_wen;
    int          exp_lat;
  } vec_t;

  vec_t vt[13];

  // Driver: presents one op, plays memory, checks request and write-back.
  task automatic run_op(input vec_t v, input int idx);
    int   k, req_n, wait_n;
    logic hs, rdy_now;
    logic [31:0] exp_q[$];
    @(negedge clk);
    in_valid            = 1'b1;
    in_pc               = 32'h1000 + 32'(idx) * 32'd4;
    in_alu_result       = v.addr;
    in_wdata            = v.wdata;
    in_width            = v.width;
    in_is_load          = v.is_load;
    in_is_store         = v.is_store;
    in_is_load_unsigned = v.is_uns;
    in_rd_addr          = 5'(idx + 1);
    in_rd_wen           = v.rd_wen;
    @(posedge clk); #1;
    // Scramble the op fields so only latched copies can be used.
    in_valid            = 1'b0;
    in_alu_result       = 32'hFFFF_FFFF;
    in_wdata            = 32'h0;
    in_width            = 2'd0;
    in_is_load_unsigned = ~v.is_uns;
    k = 0; req_n = 0; wait_n = 0; hs = 1'b0;
    while (wb_valid !== 1'b1 && k < 40) begin
      dmem.req_ready  = 1'b0;
      dmem.resp_valid = 1'b0;
      rdy_now = 1'b0;
      chk($sformatf("v%0d stall", idx), 32'(stall), 32'(v.exp_req));
      chk($sformatf("v%0d req_valid", idx), 32'(dmem.req_valid), 32'(v.exp_req && !hs));
      if (dmem.req_valid === 1'b1) begin
        chk($sformatf("v%0d req_we", idx), 32'(dmem.req_we), 32'(v.exp_we));
        chk($sformatf("v%0d req_addr", idx), dmem.req_addr, v.exp_addr);
        chk($sformatf("v%0d req_wdata", idx), dmem.req_wdata, v.exp_wdata);
        chk($sformatf("v%0d req_be", idx), 32'(dmem.req_be), 32'(v.exp_be));
        // Junk response while requesting must be ignored.
        dmem.resp_valid = 1'b1;
        dmem.resp_rdata = 32'h5A5A_5A5A;
        if (req_n == v.rdy_dly) begin
          dmem.req_ready = 1'b1;
          rdy_now = 1'b1;
        end
        req_n++;
      end else if (hs) begin
        wait_n++;
        if (wait_n == v.rsp_dly) begin
          dmem.resp_valid = 1'b1;
          dmem.resp_rdata = v.rdata;
        end
      end
      @(posedge clk); #1;
      if (rdy_now) hs = 1'b1;
      k++;
    end
    dmem.req_ready  = 1'b0;
    dmem.resp_valid = 1'b0;
    chk($sformatf("v%0d latency", idx), 32'(k + 1), 32'(v.exp_lat));
    chk($sformatf("v%0d wb_valid", idx), 32'(wb_valid), 32'd1);
    chk($sformatf("v%0d stall_done", idx), 32'(stall), 32'd0);
    exp_q.push_back(32'h1000 + 32'(idx) * 32'd4);
    exp_q.push_back(v.addr);
    chk($sformatf("v%0d wb_pc", idx), wb_pc, exp_q.pop_front());
    chk($sformatf("v%0d wb_alu_result", idx), wb_alu_result, exp_q.pop_front());
    chk($sformatf("v%0d wb_rd_addr", idx), 32'(wb_rd_addr), 32'(idx + 1));
    chk($sformatf("v%0d wb_rd_wen", idx), 32'(wb_rd_wen), 32'(v.exp_rd_wen));
    chk($sformatf("v%0d wb_misaligned", idx), 32'(wb_misaligned), 32'(v.exp_mis));
    if (!v.exp_mis) begin
      chk($sformatf("v%0d wb_r_data", idx), wb_r_data, v.exp_rdata);
      chk($sformatf("v%0d wb_is_load", idx), 32'(wb_is_load), 32'(v.exp_is_load));
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d wb_pulse", idx), 32'(wb_valid), 32'd0);
    chk($sformatf("v%0d mis_pulse", idx), 32'(wb_misaligned), 32'd0);
  endtask

  initial begin
    // is_load,is_store,uns,width, addr,wdata,rdata, rdy,rsp, rd_wen,
    // exp_req,we, addr,wdata,be, rdata, is_load,mis,rd_wen, lat
    vt[0]  = '{1'b0,1'b0,1'b0,2'd2, 32'h1234,32'h0,32'h0, 0,0, 1'b1,
               1'b0,1'b0, 32'h0,32'h0,4'h0, 32'h0, 1'b0,1'b0,1'b1, 1};
    vt[1]  = '{1'b0,1'b1,1'b0,2'd0, 32'h103,32'hAB,32'h0, 3,0, 1'b0,
               1'b1,1'b1, 32'h100,32'hABABABAB,4'b1000, 32'h0, 1'b0,1'b0,1'b0, 5};
    vt[2]  = '{1'b1,1'b0,1'b0,2'd0, 32'h102,32'h0,32'h00800000, 0,1, 1'b1,
               1'b1,1'b0, 32'h100,32'h0,4'b0100, 32'hFFFFFF80, 1'b1,1'b0,1'b1, 3};
    vt[3]  = '{1'b1,1'b0,1'b1,2'd0, 32'h102,32'h0,32'h00800000, 0,1, 1'b1,
               1'b1,1'b0, 32'h100,32'h0,4'b0100, 32'h00000080, 1'b1,1'b0,1'b1, 3};
    vt[4]  = '{1'b1,1'b0,1'b0,2'd1, 32'h102,32'h0,32'hBEEF0000, 0,4, 1'b1,
               1'b1,1'b0, 32'h100,32'h0,4'b1100, 32'hFFFFBEEF, 1'b1,1'b0,1'b1, 6};
    vt[5]  = '{1'b1,1'b0,1'b0,2'd2, 32'h101,32'h0,32'h0, 0,0, 1'b1,
               1'b0,1'b0, 32'h0,32'h0,4'h0, 32'h0, 1'b1,1'b1,1'b0, 1};
    vt[6]  = '{1'b0,1'b1,1'b0,2'd1, 32'h102,32'h12345678,32'h0, 1,0, 1'b0,
               1'b1,1'b1, 32'h100,32'h56785678,4'b1100, 32'h0, 1'b0,1'b0,1'b0, 3};
    vt[7]  = '{1'b0,1'b1,1'b0,2'd3, 32'h200,32'hDEADBEEF,32'h0, 0,0, 1'b0,
               1'b1,1'b1, 32'h200,32'hDEADBEEF,4'b1111, 32'h0, 1'b0,1'b0,1'b0, 2};
    vt[8]  = '{1'b1,1'b0,1'b0,2'd2, 32'h204,32'h0,32'h80000001, 2,2, 1'b1,
               1'b1,1'b0, 32'h204,32'h0,4'b1111, 32'h80000001, 1'b1,1'b0,1'b1, 6};
    vt[9]  = '{1'b1,1'b0,1'b1,2'd1, 32'h100,32'h0,32'h12348765, 0,1, 1'b1,
               1'b1,1'b0, 32'h100,32'h0,4'b0011, 32'h00008765, 1'b1,1'b0,1'b1, 3};
    vt[10] = '{1'b1,1'b0,1'b0,2'd0, 32'h101,32'h0,32'h00007F00, 0,2, 1'b1,
               1'b1,1'b0, 32'h100,32'h0,4'b0010, 32'h0000007F, 1'b1,1'b0,1'b1, 4};
    vt[11] = '{1'b0,1'b1,1'b0,2'd1, 32'h103,32'h55,32'h0, 0,0, 1'b1,
               1'b0,1'b0, 32'h0,32'h0,4'h0, 32'h0, 1'b0,1'b1,1'b0, 1};
    vt[12] = '{1'b1,1'b1,1'b0,2'd2, 32'h10,32'h11,32'hCAFEF00D, 0,1, 1'b1,
               1'b1,1'b0, 32'h10,32'h11,4'b1111, 32'hCAFEF00D, 1'b1,1'b0,1'b1, 3};

    rst = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_alu_result = '0; in_wdata = '0; in_width = '0;
    in_is_load = 1'b0; in_is_store = 1'b0; in_is_load_unsigned = 1'b0;
    in_rd_addr = '0; in_rd_wen = 1'b0;
    dmem.req_ready = 1'b0; dmem.resp_valid = 1'b0; dmem.resp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst req_valid", 32'(dmem.req_valid), 32'd0);
    chk("rst req_addr", dmem.req_addr, 32'd0);
    chk("rst req_be", 32'(dmem.req_be), 32'd0);
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst wb_pc", wb_pc, 32'd0);
    chk("rst wb_r_data", wb_r_data, 32'd0);
    chk("rst wb_rd_wen", 32'(wb_rd_wen), 32'd0);
    chk("rst state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_op(vt[i], i);

    // Reset while waiting for load data, then a late response.
    @(negedge clk);
    in_valid = 1'b1; in_alu_result = 32'h300; in_width = 2'd2;
    in_is_load = 1'b1; in_is_store = 1'b0; in_rd_addr = 5'd9; in_rd_wen = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dmem.req_ready = 1'b1;
    @(posedge clk); #1;
    dmem.req_ready = 1'b0;
    chk("wait state", 32'(dbg_state), 32'(WAIT));
    chk("wait stall", 32'(stall), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw state", 32'(dbg_state), 32'(IDLE));
    chk("rstw stall", 32'(stall), 32'd0);
    chk("rstw wb_pc", wb_pc, 32'd0);
    dmem.resp_valid = 1'b1; dmem.resp_rdata = 32'h7777_7777;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      dmem.resp_valid = 1'b0;
      chk($sformatf("rstw wb_valid c%0d", c), 32'(wb_valid), 32'd0);
      chk($sformatf("rstw req_valid c%0d", c), 32'(dmem.req_valid), 32'd0);
    end

    // Reset while a store request is stalled on ready.
    @(negedge clk);
    in_valid = 1'b1; in_alu_result = 32'h400; in_width = 2'd2;
    in_is_load = 1'b0; in_is_store = 1'b1; in_wdata = 32'h1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rstr req_valid_before", 32'(dmem.req_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstr req_valid_after", 32'(dmem.req_valid), 32'd0);
    @(posedge clk); #1;
    chk("rstr wb_valid", 32'(wb_valid), 32'd0);

    run_op(vt[2], 2);
    run_op(vt[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
